// File: rtl/my_datapath_pkg.sv
// rtl/my_datapath_pkg.sv - shared widths, slot indices and ALU opcodes
package my_datapath_pkg;

  localparam int W     = 23;
  localparam int NREG  = 20;
  localparam int OFS_W = 20;

  localparam int IDX_R0  = 0;
  localparam int IDX_R1  = 1;
  localparam int IDX_R2  = 2;
  localparam int IDX_R3  = 3;
  localparam int IDX_R4  = 4;
  localparam int IDX_R5  = 5;
  localparam int IDX_R6  = 6;
  localparam int IDX_R7  = 7;
  localparam int IDX_R8  = 8;
  localparam int IDX_R9  = 9;
  localparam int IDX_R10 = 10;
  localparam int IDX_R11 = 11;
  localparam int IDX_R12 = 12;
  localparam int IDX_R13 = 13;
  localparam int IDX_R14 = 14;
  localparam int IDX_R15 = 15;
  localparam int IDX_PC  = 16;
  localparam int IDX_IR  = 17;
  localparam int IDX_A   = 18;
  localparam int IDX_G   = 19;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_SHL   = 3'b101,
    ALU_PASSB = 3'b110,
    ALU_PASSA = 3'b111
  } alu_op_e;

  // Branch offset field sign-extended to the datapath width.
  function automatic logic [W-1:0] sext_ofs(input logic [OFS_W-1:0] v);
    return {{(W-OFS_W){v[OFS_W-1]}}, v};
  endfunction

endpackage

// File: rtl/my_datapath_alu.sv
// rtl/my_datapath_alu.sv - combinational ALU feeding the G slot
// Ports: a (A latch), b (bus), op (IR opcode field) -> y (result, mod 2^W)
module my_alu
  import my_datapath_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    case (alu_op_e'(op))
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_XOR:   y = a ^ b;
      ALU_SHL:   y = a << 1;
      ALU_PASSB: y = b;
      ALU_PASSA: y = a;
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/my_datapath.sv
// rtl/my_datapath.sv - register file and shared-bus datapath under controller command
// Ports: clk, rst (sync active-high); r_en_OH load enables; tri_controller_OH bus
//        driver selects; branch, inc_pc PC commands; din external data.
//        code {IR opcode, G low bits}, inst_reg, bus, pc, err_conflict (sticky),
//        xfer_cnt (load-cycle counter, wraps).
module my_datapath
  import my_datapath_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NREG-1:0] r_en_OH,
  input  logic [NREG-1:0] tri_controller_OH,
  input  logic            branch,
  input  logic            inc_pc,
  input  logic [W-1:0]    din,
  output logic [W-1:0]    code,
  output logic [W-1:0]    inst_reg,
  output logic [W-1:0]    bus,
  output logic [W-1:0]    pc,
  output logic            err_conflict,
  output logic [15:0]     xfer_cnt
);

  logic [W-1:0] slots [NREG];
  logic         no_driver;
  logic         conflict;
  logic [W-1:0] sel_val;
  logic [W-1:0] alu_y;

  // x & (x-1) clears the lowest set bit; anything left means two or more drivers.
  assign no_driver = (tri_controller_OH == '0);
  assign conflict  = |(tri_controller_OH & (tri_controller_OH - {{(NREG-1){1'b0}}, 1'b1}));

  // With exactly one driver, OR-ing the masked slots selects it.
  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NREG; i++) begin
      sel_val = sel_val | (slots[i] & {W{tri_controller_OH[i]}});
    end
  end

  always_comb begin
    bus = sel_val;
    if (no_driver) begin
      bus = din;
    end else if (conflict) begin
      bus = '0;
    end
  end

  my_alu u_alu (
    .a  (slots[IDX_A]),
    .b  (bus),
    .op (slots[IDX_IR][W-1:OFS_W]),
    .y  (alu_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        slots[i] <= '0;
      end
      err_conflict <= 1'b0;
      xfer_cnt     <= '0;
    end else if (conflict) begin
      err_conflict <= 1'b1;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (r_en_OH[i] && i != IDX_PC) begin
          slots[i] <= (i == IDX_G) ? alu_y : bus;
        end
      end
      // Bus load beats branch beats increment; all use the pre-edge PC and IR.
      if (r_en_OH[IDX_PC]) begin
        slots[IDX_PC] <= bus;
      end else if (branch) begin
        slots[IDX_PC] <= slots[IDX_PC] + sext_ofs(slots[IDX_IR][OFS_W-1:0]);
      end else if (inc_pc) begin
        slots[IDX_PC] <= slots[IDX_PC] + {{(W-1){1'b0}}, 1'b1};
      end
      if (r_en_OH != '0) begin
        xfer_cnt <= xfer_cnt + 16'd1;
      end
    end
  end

  assign pc       = slots[IDX_PC];
  assign inst_reg = slots[IDX_IR];
  assign code     = {slots[IDX_IR][W-1:OFS_W], slots[IDX_G][OFS_W-1:0]};

endmodule

// File: tb/tb_my_datapath.sv
// tb/tb_my_datapath.sv - directed self-checking bench for my_datapath
module tb_my_datapath;

  logic        clk;
  logic        rst;
  logic [19:0] r_en_OH;
  logic [19:0] tri_controller_OH;
  logic        branch;
  logic        inc_pc;
  logic [22:0] din;
  logic [22:0] code;
  logic [22:0] inst_reg;
  logic [22:0] bus;
  logic [22:0] pc;
  logic        err_conflict;
  logic [15:0] xfer_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  my_datapath dut (
    .clk               (clk),
    .rst               (rst),
    .r_en_OH           (r_en_OH),
    .tri_controller_OH (tri_controller_OH),
    .branch            (branch),
    .inc_pc            (inc_pc),
    .din               (din),
    .code              (code),
    .inst_reg          (inst_reg),
    .bus               (bus),
    .pc                (pc),
    .err_conflict      (err_conflict),
    .xfer_cnt          (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    r_en_OH           = '0;
    tri_controller_OH = '0;
    branch            = 1'b0;
    inc_pc            = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    din = 23'h012345;
    step();
    rst = 1'b0;
    #1;
    total_cnt++;
    if (bus !== 23'h012345) $display("FAIL reset_bus: got %h expected %h", bus, 23'h012345); else pass_cnt++;
    total_cnt++;
    if (pc !== 23'h0) $display("FAIL reset_pc: got %h expected %h", pc, 23'h0); else pass_cnt++;
    total_cnt++;
    if (inst_reg !== 23'h0) $display("FAIL reset_ir: got %h expected %h", inst_reg, 23'h0); else pass_cnt++;
    total_cnt++;
    if (code !== 23'h0) $display("FAIL reset_code: got %h expected %h", code, 23'h0); else pass_cnt++;
    total_cnt++;
    if (err_conflict !== 1'b0) $display("FAIL reset_err: got %b expected %b", err_conflict, 1'b0); else pass_cnt++;
    total_cnt++;
    if (xfer_cnt !== 16'h0) $display("FAIL reset_xfer: got %h expected %h", xfer_cnt, 16'h0); else pass_cnt++;
  endtask

  task automatic test_load_copy();
    din = 23'h000ABC; r_en_OH = 20'h00008;
    step();
    idle();
    din = 23'h000000;
    tri_controller_OH = 20'h00008; r_en_OH = 20'h000A0;
    #1;
    total_cnt++;
    if (bus !== 23'h000ABC) $display("FAIL copy_bus_r3: got %h expected %h", bus, 23'h000ABC); else pass_cnt++;
    step();
    idle();
    tri_controller_OH = 20'h00020;
    #1;
    total_cnt++;
    if (bus !== 23'h000ABC) $display("FAIL copy_r5: got %h expected %h", bus, 23'h000ABC); else pass_cnt++;
    tri_controller_OH = 20'h00080;
    #1;
    total_cnt++;
    if (bus !== 23'h000ABC) $display("FAIL copy_r7: got %h expected %h", bus, 23'h000ABC); else pass_cnt++;
    total_cnt++;
    if (xfer_cnt !== 16'd2) $display("FAIL copy_xfer: got %0d expected %0d", xfer_cnt, 2); else pass_cnt++;
    // Same slot as driver and destination keeps its value.
    tri_controller_OH = 20'h00008; r_en_OH = 20'h00008;
    step();
    idle();
    tri_controller_OH = 20'h00008;
    #1;
    total_cnt++;
    if (bus !== 23'h000ABC) $display("FAIL self_copy_r3: got %h expected %h", bus, 23'h000ABC); else pass_cnt++;
    idle();
  endtask

  task automatic test_alu_add();
    din = 23'h000000; r_en_OH = 20'h20000;
    step();
    din = 23'h7FFFFF; r_en_OH = 20'h40000;
    step();
    din = 23'h000002; r_en_OH = 20'h00002;
    step();
    idle();
    din = 23'h000000;
    tri_controller_OH = 20'h00002; r_en_OH = 20'h80000;
    step();
    idle();
    total_cnt++;
    if (code !== 23'h000001) $display("FAIL alu_add_code: got %h expected %h", code, 23'h000001); else pass_cnt++;
    tri_controller_OH = 20'h80000;
    #1;
    total_cnt++;
    if (bus !== 23'h000001) $display("FAIL alu_add_g: got %h expected %h", bus, 23'h000001); else pass_cnt++;
    total_cnt++;
    if (xfer_cnt !== 16'd7) $display("FAIL alu_xfer: got %0d expected %0d", xfer_cnt, 7); else pass_cnt++;
    idle();
  endtask

  task automatic test_pc_priority();
    din = 23'h7FFFFF; r_en_OH = 20'h10000;
    step();
    idle();
    total_cnt++;
    if (pc !== 23'h7FFFFF) $display("FAIL pc_load_max: got %h expected %h", pc, 23'h7FFFFF); else pass_cnt++;
    inc_pc = 1'b1;
    step();
    idle();
    total_cnt++;
    if (pc !== 23'h000000) $display("FAIL pc_inc_wrap: got %h expected %h", pc, 23'h000000); else pass_cnt++;
    din = 23'h0FFFFE; r_en_OH = 20'h20000;
    step();
    idle();
    total_cnt++;
    if (inst_reg !== 23'h0FFFFE) $display("FAIL ir_load: got %h expected %h", inst_reg, 23'h0FFFFE); else pass_cnt++;
    branch = 1'b1; inc_pc = 1'b1;
    step();
    idle();
    total_cnt++;
    if (pc !== 23'h7FFFFE) $display("FAIL pc_branch_neg: got %h expected %h", pc, 23'h7FFFFE); else pass_cnt++;
    din = 23'h000100; r_en_OH = 20'h10000; branch = 1'b1;
    step();
    idle();
    total_cnt++;
    if (pc !== 23'h000100) $display("FAIL pc_load_over_branch: got %h expected %h", pc, 23'h000100); else pass_cnt++;
    total_cnt++;
    if (xfer_cnt !== 16'd10) $display("FAIL pc_xfer: got %0d expected %0d", xfer_cnt, 10); else pass_cnt++;
  endtask

  task automatic test_conflict();
    din = 23'h000055; r_en_OH = 20'h00004;
    step();
    idle();
    din = 23'h000999;
    tri_controller_OH = 20'h00003; r_en_OH = 20'h00004; inc_pc = 1'b1;
    #1;
    total_cnt++;
    if (bus !== 23'h000000) $display("FAIL conflict_bus: got %h expected %h", bus, 23'h000000); else pass_cnt++;
    step();
    idle();
    total_cnt++;
    if (pc !== 23'h000100) $display("FAIL conflict_pc: got %h expected %h", pc, 23'h000100); else pass_cnt++;
    total_cnt++;
    if (xfer_cnt !== 16'd11) $display("FAIL conflict_xfer: got %0d expected %0d", xfer_cnt, 11); else pass_cnt++;
    total_cnt++;
    if (err_conflict !== 1'b1) $display("FAIL conflict_err_set: got %b expected %b", err_conflict, 1'b1); else pass_cnt++;
    tri_controller_OH = 20'h00004;
    #1;
    total_cnt++;
    if (bus !== 23'h000055) $display("FAIL conflict_r2: got %h expected %h", bus, 23'h000055); else pass_cnt++;
    step();
    idle();
    total_cnt++;
    if (err_conflict !== 1'b1) $display("FAIL conflict_err_sticky: got %b expected %b", err_conflict, 1'b1); else pass_cnt++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total_cnt++;
    if (err_conflict !== 1'b0) $display("FAIL conflict_err_clear: got %b expected %b", err_conflict, 1'b0); else pass_cnt++;
    total_cnt++;
    if (xfer_cnt !== 16'd0) $display("FAIL conflict_rst_xfer: got %0d expected %0d", xfer_cnt, 0); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    din = 23'h300000; r_en_OH = 20'h20000;
    step();
    idle();
    inc_pc = 1'b1;
    step();
    idle();
    total_cnt++;
    if (inst_reg !== 23'h300000) $display("FAIL mid_ir_pre: got %h expected %h", inst_reg, 23'h300000); else pass_cnt++;
    total_cnt++;
    if (pc !== 23'h000001) $display("FAIL mid_pc_pre: got %h expected %h", pc, 23'h000001); else pass_cnt++;
    rst = 1'b1; din = 23'h000777; r_en_OH = 20'h20000; inc_pc = 1'b1;
    step();
    rst = 1'b0;
    idle();
    total_cnt++;
    if (inst_reg !== 23'h0) $display("FAIL mid_ir: got %h expected %h", inst_reg, 23'h0); else pass_cnt++;
    total_cnt++;
    if (pc !== 23'h0) $display("FAIL mid_pc: got %h expected %h", pc, 23'h0); else pass_cnt++;
    total_cnt++;
    if (code !== 23'h0) $display("FAIL mid_code: got %h expected %h", code, 23'h0); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    din = '0;
    idle();
    test_reset();
    test_load_copy();
    test_alu_add();
    test_pc_priority();
    test_conflict();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
